// File: rtl/benes_route_ctrl.sv
// Routing controller for the 8-port, 5-stage Benes network: stores permutation contexts
// and pipelines each issued vector's context ID so every stage sees that vector's setting.
module benes_route_ctrl #(
  parameter int unsigned NUM_CTX = 4,
  localparam int unsigned CTX_W = $clog2(NUM_CTX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CTX_W-1:0]      cfg_ctx,
  input  logic [4:0][3:0]       cfg_sw,
  input  logic                  clr_req,
  output logic                  clr_done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTX_W-1:0]      in_ctx,
  output logic [4:0][3:0]       switch_set,
  output logic                  out_valid,
  output logic [CTX_W-1:0]      out_ctx,
  output logic                  busy
);

  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e                          state_q, state_d;
  logic [NUM_CTX-1:0][4:0][3:0]    tbl_q;
  logic [NUM_CTX-1:0]              ctx_vld_q;
  // Index 0 holds stage 1, index 3 holds stage 4.
  logic [3:0]                      v_q;
  logic [3:0][CTX_W-1:0]           c_q;

  logic issue;
  logic cfg_wr;
  logic hazard;
  logic clr_all;

  assign issue     = in_valid && in_ready;
  assign cfg_wr    = cfg_valid && cfg_ready;
  assign busy      = |v_q;
  assign out_valid = v_q[3];
  assign out_ctx   = c_q[3];

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    clr_done  = 1'b0;
    clr_all   = 1'b0;
    // A context referenced by any in-flight or issuing vector must not be rewritten.
    hazard    = in_valid && (in_ctx == cfg_ctx);
    for (int k = 0; k < 4; k++) begin
      if (v_q[k] && (c_q[k] == cfg_ctx)) hazard = 1'b1;
    end
    case (state_q)
      StRun: begin
        in_ready  = ctx_vld_q[in_ctx];
        cfg_ready = !hazard;
        if (clr_req) state_d = StDrain;
      end
      StDrain: begin
        if (!busy) state_d = StClear;
      end
      StClear: begin
        clr_done = 1'b1;
        clr_all  = 1'b1;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    switch_set    = '0;
    switch_set[0] = issue ? tbl_q[in_ctx][0] : 4'b0;
    for (int k = 1; k < 5; k++) begin
      switch_set[k] = v_q[k-1] ? tbl_q[c_q[k-1]][k] : 4'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      tbl_q     <= '0;
      ctx_vld_q <= '0;
      v_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= {v_q[2:0], issue};
      c_q     <= {c_q[2:0], (issue ? in_ctx : {CTX_W{1'b0}})};
      if (cfg_wr) begin
        tbl_q[cfg_ctx]     <= cfg_sw;
        ctx_vld_q[cfg_ctx] <= 1'b1;
      end
      if (clr_all) ctx_vld_q <= '0;
    end
  end

endmodule

// File: tb/tb_benes_route_ctrl.sv
// Directed bench for benes_route_ctrl: context table, stage alignment, write hazards,
// drain-then-clear sequencing and mid-flight reset.
module tb_benes_route_ctrl;

  logic            clk;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ctx;
  logic [4:0][3:0] cfg_sw;
  logic            clr_req;
  logic            clr_done;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_ctx;
  logic [4:0][3:0] switch_set;
  logic            out_valid;
  logic [1:0]      out_ctx;
  logic            busy;

  int checks;
  int failures;
  logic [19:0] tab [4];
  logic [1:0]  oc [3];
  logic [19:0] e;

  benes_route_ctrl #(.NUM_CTX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ctx    (cfg_ctx),
    .cfg_sw     (cfg_sw),
    .clr_req    (clr_req),
    .clr_done   (clr_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctx     (in_ctx),
    .switch_set (switch_set),
    .out_valid  (out_valid),
    .out_ctx    (out_ctx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ctx, input logic [19:0] sw);
    cfg_valid = 1'b1;
    cfg_ctx   = ctx;
    cfg_sw    = sw;
    #1;
    chk("wr_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    step;
    cfg_valid = 1'b0;
    tab[ctx]  = sw;
  endtask

  // Expected switch_set in cycle j of the ctx0,ctx1,ctx0,ctx1 burst.
  function automatic logic [19:0] exp_burst(input int j);
    logic [19:0] res;
    logic [19:0] ent;
    res = '0;
    for (int k = 0; k < 5; k++) begin
      if ((j - k) >= 0 && (j - k) < 4) begin
        ent = tab[(j - k) % 2];
        res[4*k +: 4] = ent[4*k +: 4];
      end
    end
    return res;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ctx = '0;
    cfg_sw = '0;
    clr_req = 1'b0;
    in_valid = 1'b0;
    in_ctx = '0;
    for (int i = 0; i < 4; i++) tab[i] = '0;
    step;
    step;
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_ctx", {30'b0, out_ctx}, 0);
    chk("rst_switch_set", {12'b0, switch_set}, 0);
    chk("rst_clr_done", {31'b0, clr_done}, 0);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 1);

    // Unprogrammed context is never issued.
    in_valid = 1'b1;
    in_ctx = 2'd0;
    #1;
    chk("t1_in_ready", {31'b0, in_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t1_out_valid", {31'b0, out_valid}, 0);
    end
    in_valid = 1'b0;
    step;

    wr(2'd0, 20'h12345);
    wr(2'd1, 20'h35A0F);
    wr(2'd2, 20'h77777);
    wr(2'd3, 20'hBBBBB);

    // Single vector through all five stages.
    in_valid = 1'b1;
    in_ctx = 2'd1;
    #1;
    chk("t2_in_ready", {31'b0, in_ready}, 1);
    chk("t2_sw0", {12'b0, switch_set}, 32'h0000F);
    step;
    in_valid = 1'b0;
    #1;
    chk("t2_sw1", {12'b0, switch_set}, 32'h00000);
    chk("t2_busy", {31'b0, busy}, 1);
    chk("t2_ov1", {31'b0, out_valid}, 0);
    step;
    chk("t2_sw2", {12'b0, switch_set}, 32'h00A00);
    step;
    chk("t2_sw3", {12'b0, switch_set}, 32'h05000);
    chk("t2_ov3", {31'b0, out_valid}, 0);
    step;
    chk("t2_sw4", {12'b0, switch_set}, 32'h30000);
    chk("t2_ov4", {31'b0, out_valid}, 1);
    chk("t2_oc4", {30'b0, out_ctx}, 1);
    step;
    chk("t2_sw5", {12'b0, switch_set}, 32'h0);
    chk("t2_ov5", {31'b0, out_valid}, 0);
    chk("t2_busy5", {31'b0, busy}, 0);

    // Back-to-back ctx0,ctx1,ctx0,ctx1.
    for (int j = 0; j < 8; j++) begin
      in_valid = (j < 4);
      in_ctx = 2'(j % 2);
      #1;
      if (j < 4) chk("t3_in_ready", {31'b0, in_ready}, 1);
      chk("t3_sw", {12'b0, switch_set}, {12'b0, exp_burst(j)});
      chk("t3_ov", {31'b0, out_valid}, {31'b0, (j >= 4)});
      if (j >= 4) chk("t3_oc", {30'b0, out_ctx}, 32'((j - 4) % 2));
      step;
    end

    // Write to an in-flight context is held off until the vector leaves.
    in_valid = 1'b1;
    in_ctx = 2'd2;
    #1;
    chk("t4_in_ready", {31'b0, in_ready}, 1);
    chk("t4_sw0", {12'b0, switch_set}, 32'h00007);
    step;
    in_valid = 1'b0;
    cfg_valid = 1'b1;
    cfg_ctx = 2'd2;
    cfg_sw = 20'h99999;
    for (int k = 1; k < 5; k++) begin
      #1;
      e = 20'h7 << (4 * k);
      chk("t4_cfg_blocked", {31'b0, cfg_ready}, 0);
      chk("t4_sw_old", {12'b0, switch_set}, {12'b0, e});
      step;
    end
    #1;
    chk("t4_cfg_free", {31'b0, cfg_ready}, 1);
    step;
    cfg_valid = 1'b0;
    tab[2] = 20'h99999;
    in_valid = 1'b1;
    in_ctx = 2'd2;
    #1;
    chk("t4_sw_new0", {12'b0, switch_set}, 32'h00009);
    step;
    in_valid = 1'b0;
    step;
    step;
    step;
    chk("t4_sw_new4", {12'b0, switch_set}, 32'h90000);
    step;

    // Issue wins over a same-context write; a different context writes alongside.
    in_valid = 1'b1;
    in_ctx = 2'd3;
    cfg_valid = 1'b1;
    cfg_ctx = 2'd3;
    cfg_sw = 20'hEEEEE;
    #1;
    chk("t5_in_ready_a", {31'b0, in_ready}, 1);
    chk("t5_cfg_ready_a", {31'b0, cfg_ready}, 0);
    step;
    cfg_ctx = 2'd2;
    cfg_sw = 20'h12121;
    #1;
    chk("t5_in_ready_b", {31'b0, in_ready}, 1);
    chk("t5_cfg_ready_b", {31'b0, cfg_ready}, 1);
    chk("t5_sw_b", {12'b0, switch_set}, 32'h000BB);
    step;
    in_valid = 1'b0;
    cfg_valid = 1'b0;
    step;
    step;
    step;
    step;
    chk("t5_drained", {31'b0, busy}, 0);
    in_valid = 1'b1;
    in_ctx = 2'd2;
    #1;
    chk("t5_ctx2_new", {12'b0, switch_set}, 32'h00001);
    step;
    in_ctx = 2'd3;
    #1;
    chk("t5_ctx3_kept", {12'b0, switch_set}, 32'h0002B);
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step;

    // Drain-then-clear.
    oc[0] = 2'd0;
    oc[1] = 2'd1;
    oc[2] = 2'd3;
    in_valid = 1'b1;
    in_ctx = 2'd0;
    step;
    in_ctx = 2'd1;
    step;
    in_ctx = 2'd3;
    clr_req = 1'b1;
    #1;
    chk("t6_in_ready_clr", {31'b0, in_ready}, 1);
    step;
    clr_req = 1'b0;
    in_ctx = 2'd0;
    for (int m = 3; m < 8; m++) begin
      #1;
      chk("t6_in_blocked", {31'b0, in_ready}, 0);
      chk("t6_ov", {31'b0, out_valid}, {31'b0, (m >= 4 && m <= 6)});
      if (m >= 4 && m <= 6) chk("t6_oc", {30'b0, out_ctx}, {30'b0, oc[m-4]});
      chk("t6_clr_done_early", {31'b0, clr_done}, 0);
      step;
    end
    #1;
    chk("t6_clr_done", {31'b0, clr_done}, 1);
    chk("t6_in_blocked_clr", {31'b0, in_ready}, 0);
    step;
    in_valid = 1'b0;
    #1;
    chk("t6_clr_done_off", {31'b0, clr_done}, 0);
    chk("t6_cfg_ready_run", {31'b0, cfg_ready}, 1);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_ctx = 2'(c);
      #1;
      chk("t6_ctx_invalid", {31'b0, in_ready}, 0);
    end
    in_valid = 1'b0;
    step;

    // Reset while a vector is in flight drops it.
    wr(2'd1, 20'h35A0F);
    in_valid = 1'b1;
    in_ctx = 2'd1;
    #1;
    chk("t7_in_ready", {31'b0, in_ready}, 1);
    step;
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk("t7_busy", {31'b0, busy}, 0);
    chk("t7_sw", {12'b0, switch_set}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t7_ov", {31'b0, out_valid}, 0);
      step;
    end
    in_valid = 1'b1;
    in_ctx = 2'd1;
    #1;
    chk("t7_ctx_vld_reset", {31'b0, in_ready}, 0);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
